mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch bus (ibus, read-only) and the data bus (dbus, read/write).
- Sits between the fetch stage / memory stage and the memory/cache interface.
- Serves one transaction at a time and holds the grant until the memory returns data_ok.
- Requesters see the usual valid / addr_ok / data_ok handshake and stall as they do today when data_ok is low.

Parameters:
- ADDR_W, 64, address width (u64).
- DATA_W, 64, data width.
- STRB_W, DATA_W/8, write-strobe width.

Ports:
- clk in 1: clock, posedge.
- rst in 1: reset, asynchronous, active-high.
- ireq_valid in 1: ibus request valid.
- ireq_addr in 64: ibus address.
- iresp_addr_ok out 1: ibus address accepted.
- iresp_data_ok out 1: ibus data returned.
- iresp_data out 64: ibus read data.
- dreq_valid in 1: dbus request valid.
- dreq_addr in 64: dbus address.
- dreq_size in 3: access size, log2 bytes.
- dreq_strobe in 8: byte write enables; 0 means read.
- dreq_wdata in 64: dbus write data.
- dresp_addr_ok out 1: dbus address accepted.
- dresp_data_ok out 1: dbus data returned.
- dresp_data out 64: dbus read data.
- mreq_valid out 1: memory request valid.
- mreq_addr out 64: memory address.
- mreq_size out 3: memory access size.
- mreq_strobe out 8: memory byte enables.
- mreq_wdata out 64: memory write data.
- mresp_addr_ok in 1: memory address accepted.
- mresp_data_ok in 1: memory data returned.
- mresp_data in 64: memory read data.

Behaviour:
- Clocking and reset: single clock clk; rst is asynchronous and active-high.
- Reset values:
  - state=IDLE;
  - mreq_valid=0;
  - mreq_addr, mreq_size, mreq_strobe, mreq_wdata = 0;
  - all requester addr_ok and data_ok = 0;
  - last_grant=D.
- States: IDLE, BUSY_I, BUSY_D. This is the only FSM.
- IDLE:
  - No request: stay in IDLE; mreq_valid=0.
  - On the clock edge with any request valid: choose the winner by the priority rule, then latch into the request register:
    - ibus: ireq_addr, size=3'd2, strobe=0, wdata=0.
    - dbus: dreq_addr, dreq_size, dreq_strobe, dreq_wdata.
  - Next state is BUSY_I or BUSY_D.
- BUSY_x:
  - mreq_valid=1 and mreq_* are driven from the latched register, stable for the whole transaction.
  - The granted requester's addr_ok = mresp_addr_ok and data_ok = mresp_data_ok, passed through combinationally. Its data = mresp_data.
  - The non-granted requester sees addr_ok=data_ok=0 and data=0.
  - On the edge where mresp_data_ok=1: go to IDLE, set mreq_valid=0, and update last_grant.
- Latency and throughput:
  - Issue latency: request seen at edge N, mreq_valid high in cycle N+1.
  - Minimum 2 cycles per transaction (IDLE plus one BUSY cycle when memory answers immediately).
  - There is always one IDLE cycle between transactions.
- Requester rules:
  - Hold valid and all request fields stable until own data_ok.
  - A requester that drops valid mid-transaction is ignored: the transaction completes and the response is discarded.
- Priority without the optional feature: fixed, dbus over ibus. Under a continuous dbus stream, ibus wins only in IDLE cycles where dreq_valid=0.
- Simultaneous events: both requests valid in IDLE means exactly one grant. The loser's valid remains pending and is arbitrated in the next IDLE.
- Reset mid-transaction: immediate return to IDLE with mreq_valid=0. Any late mresp_* is ignored. The downstream memory shares rst.
- mresp_data_ok while IDLE is ignored. An assertion fires in simulation.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are valid in IDLE, grant the requester not equal to last_grant. Single requests are granted directly. No starvation: worst-case wait is one transaction.
- Undefined: fixed dbus priority; the last_grant register is not synthesized.

Decomposition:
- Shared package common:
  - arb_state_e enum (IDLE/BUSY_I/BUSY_D);
  - grant_e enum (I/D);
  - mem_req_t struct (addr, size, strobe, wdata, valid);
  - MSIZE_WORD=3'd2 constant.
- Sub-module: mem_arb_pick, a combinational grant selection from (ireq_valid, dreq_valid, last_grant). It keeps the macro-dependent logic isolated.

Test Plan:
- ireq_valid=1, addr=0x8000_0000; memory replies data_ok one cycle after mreq_valid with data=0x00000013 -> mreq_addr=0x8000_0000, size=2, strobe=0; iresp_data_ok=1 with data 0x13 exactly one cycle; dresp_* stay 0.
- Both valid in the same IDLE cycle; dreq is a write to 0x1000, strobe=0xFF, wdata=0xDEADBEEF -> dbus is served first with mreq_strobe=0xFF; ibus is served next, after one IDLE cycle.
- dreq_valid held high for 4 back-to-back reads plus ireq_valid=1, macro undefined -> ibus gets no data_ok until dreq_valid drops. With MEM_ARB_ROUND_ROBIN_EN defined, the order is D,I,D,D,D.
- Memory stalls data_ok for 5 cycles during a BUSY_D read of 0x2008 -> mreq_* stable for all 5 cycles; dresp_data_ok=0 until cycle 5; ireq stays pending.
- rst pulsed 2 cycles into BUSY_I, then a late mresp_data_ok=1 -> mreq_valid=0 immediately; state=IDLE; no requester data_ok asserted.
- Idle bus with a spurious mresp_data_ok=1 -> no requester outputs change; assertion flagged.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory arbiter.
// Imported by mem_arb_pick and mem_bus_arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_P = 64;
  localparam int DATA_W_P = 64;
  localparam int STRB_W_P = DATA_W_P / 8;

  localparam logic [2:0] MSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  typedef struct packed {
    logic [ADDR_W_P-1:0] addr;
    logic [2:0]          size;
    logic [STRB_W_P-1:0] strobe;
    logic [DATA_W_P-1:0] wdata;
    logic                valid;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between ibus and dbus.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention, else dbus wins.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic   ireq_valid_i,
  input  logic   dreq_valid_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  grant_e last_grant_i,
`endif
  output logic   gnt_valid_o,
  output grant_e gnt_o
);

  // pick the winner among the valid requesters
  always_comb begin
    gnt_valid_o = ireq_valid_i | dreq_valid_i;
    gnt_o       = GNT_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ireq_valid_i && dreq_valid_i)
      gnt_o = (last_grant_i == GNT_D) ? GNT_I : GNT_D;
    else if (ireq_valid_i)
      gnt_o = GNT_I;
`else
    if (ireq_valid_i && !dreq_valid_i)
      gnt_o = GNT_I;
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ibus (read-only) and dbus.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed dbus priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_P,
  parameter int DATA_W = DATA_W_P,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [DATA_W-1:0] iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [STRB_W-1:0] dreq_strobe,
  input  logic [DATA_W-1:0] dreq_wdata,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [STRB_W-1:0] mreq_strobe,
  output logic [DATA_W-1:0] mreq_wdata,
  input  logic              mresp_addr_ok,
  input  logic              mresp_data_ok,
  input  logic [DATA_W-1:0] mresp_data
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_BUSY_I = BUSY_I;
  localparam logic [1:0] S_BUSY_D = BUSY_D;

  logic [1:0] state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       pick_valid;
  grant_e     pick_gnt;
  logic       gnt_i, gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e last_grant_q, last_grant_d;
`endif

  mem_arb_pick u_pick (
    .ireq_valid_i (ireq_valid),
    .dreq_valid_i (dreq_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_valid_o  (pick_valid),
    .gnt_o        (pick_gnt)
  );

  // next state and request latch: capture the winner in IDLE,
  // hold until memory returns data
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          req_d.valid = 1'b1;
          if (pick_gnt == GNT_I) begin
            state_d      = S_BUSY_I;
            req_d.addr   = ireq_addr;
            req_d.size   = MSIZE_WORD;
            req_d.strobe = '0;
            req_d.wdata  = '0;
          end else begin
            state_d      = S_BUSY_D;
            req_d.addr   = dreq_addr;
            req_d.size   = dreq_size;
            req_d.strobe = dreq_strobe;
            req_d.wdata  = dreq_wdata;
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (mresp_data_ok) begin
          state_d     = S_IDLE;
          req_d.valid = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_d.valid = 1'b0;
      end
    endcase
  end

  // state and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // remember who finished last so contention alternates
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q != S_IDLE && mresp_data_ok)
      last_grant_d = (state_q == S_BUSY_I) ? GNT_I : GNT_D;
  end

  // last-grant register, dbus after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= GNT_D;
    else     last_grant_q <= last_grant_d;
  end
`endif

  assign gnt_i = (state_q == S_BUSY_I);
  assign gnt_d = (state_q == S_BUSY_D);

  assign mreq_valid  = req_q.valid;
  assign mreq_addr   = req_q.addr;
  assign mreq_size   = req_q.size;
  assign mreq_strobe = req_q.strobe;
  assign mreq_wdata  = req_q.wdata;

  assign iresp_addr_ok = gnt_i & mresp_addr_ok;
  assign iresp_data_ok = gnt_i & mresp_data_ok;
  assign iresp_data    = gnt_i ? mresp_data : '0;
  assign dresp_addr_ok = gnt_d & mresp_addr_ok;
  assign dresp_data_ok = gnt_d & mresp_data_ok;
  assign dresp_data    = gnt_d ? mresp_data : '0;

  // data_ok with no transaction outstanding means the memory misbehaved
  always @(posedge clk) begin
    if (!rst)
      assert (!(state_q == S_IDLE && mresp_data_ok))
      else $warning("mem_bus_arbiter: mresp_data_ok while idle");
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed
// corner sequences and random traffic against a transaction model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [63:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_wdata;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_wdata;
  logic        mresp_addr_ok, mresp_data_ok;
  logic [63:0] mresp_data;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_wdata(dreq_wdata),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr),
    .mreq_size(mreq_size), .mreq_strobe(mreq_strobe),
    .mreq_wdata(mreq_wdata),
    .mresp_addr_ok(mresp_addr_ok), .mresp_data_ok(mresp_data_ok),
    .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // transaction-level model: one outstanding transaction or none
  bit          m_busy;
  bit          m_who;   // 1 = dbus
  bit          m_last;  // 1 = dbus finished last
  logic [63:0] m_addr, m_wdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strb;
  logic        e_mv, e_iaok, e_idok, e_daok, e_ddok;
  logic [63:0] e_idat, e_ddat;
  bit          model_on;
  bit          ord[$];

  function automatic bit pick_d();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ireq_valid && dreq_valid) return !m_last;
`endif
    return dreq_valid;
  endfunction

  function automatic void model_reset();
    m_busy = 0;
    m_last = 1;
  endfunction

  function automatic void model_eval();
    e_mv   = m_busy;
    e_iaok = m_busy && !m_who && mresp_addr_ok;
    e_idok = m_busy && !m_who && mresp_data_ok;
    e_idat = (m_busy && !m_who) ? mresp_data : 64'h0;
    e_daok = m_busy && m_who && mresp_addr_ok;
    e_ddok = m_busy && m_who && mresp_data_ok;
    e_ddat = (m_busy && m_who) ? mresp_data : 64'h0;
  endfunction

  function automatic void model_step();
    if (m_busy) begin
      if (mresp_data_ok) begin
        m_busy = 0;
        m_last = m_who;
      end
    end else if (ireq_valid || dreq_valid) begin
      m_busy = 1;
      m_who  = pick_d();
      if (m_who) begin
        m_addr = dreq_addr; m_size = dreq_size;
        m_strb = dreq_strobe; m_wdata = dreq_wdata;
      end else begin
        m_addr = ireq_addr; m_size = 3'd2;
        m_strb = 8'h00; m_wdata = 64'h0;
      end
    end
  endfunction

  // called at negedge with inputs set: observe and compare
  task automatic settle();
    #1;
    if (iresp_data_ok) ord.push_back(1'b0);
    if (dresp_data_ok) ord.push_back(1'b1);
    model_eval();
    if (model_on) begin
      chk("m_valid", mreq_valid, e_mv);
      if (e_mv) begin
        chk("m_addr", mreq_addr, m_addr);
        chk("m_size", mreq_size, m_size);
        chk("m_strobe", mreq_strobe, m_strb);
        chk("m_wdata", mreq_wdata, m_wdata);
      end
      chk("m_iaok", iresp_addr_ok, e_iaok);
      chk("m_idok", iresp_data_ok, e_idok);
      chk("m_idata", iresp_data, e_idat);
      chk("m_daok", dresp_addr_ok, e_daok);
      chk("m_ddok", dresp_data_ok, e_ddok);
      chk("m_ddata", dresp_data, e_ddat);
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ireq_valid = 0; ireq_addr = '0;
    dreq_valid = 0; dreq_addr = '0; dreq_size = '0;
    dreq_strobe = '0; dreq_wdata = '0;
    mresp_addr_ok = 0; mresp_data_ok = 0; mresp_data = '0;
  endtask

  typedef struct {
    logic iv; logic [63:0] ia;
    logic dv; logic [63:0] da; logic [2:0] dsz;
    logic [7:0] dst; logic [63:0] dwd;
    logic maok; logic mdok; logic [63:0] mdat;
    logic mv; logic [63:0] maddr; logic [2:0] msz;
    logic [7:0] mstb; logic [63:0] mwd;
    logic iaok; logic idok; logic [63:0] idat;
    logic daok; logic ddok; logic [63:0] ddat;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [63:0] Z   = 64'h0;
  localparam logic [63:0] IA0 = 64'h8000_0000;
  localparam logic [63:0] IA1 = 64'h8000_0004;
  localparam logic [63:0] DA  = 64'h1000;
  localparam logic [63:0] WD  = 64'hDEAD_BEEF;

  vec_t vt[9];
  int   exp_ord[5];
  int   drem;
  bit   idone, ipend, dpend;

  initial begin
    vt[0] = '{T,IA0,F,Z,3'd0,8'h00,Z, F,F,Z,
              F,Z,3'd0,8'h00,Z, F,F,Z, F,F,Z};
    vt[1] = '{T,IA0,F,Z,3'd0,8'h00,Z, T,F,Z,
              T,IA0,3'd2,8'h00,Z, T,F,Z, F,F,Z};
    vt[2] = '{T,IA0,F,Z,3'd0,8'h00,Z, F,T,64'h13,
              T,IA0,3'd2,8'h00,Z, F,T,64'h13, F,F,Z};
    vt[3] = '{F,Z,F,Z,3'd0,8'h00,Z, F,F,Z,
              F,Z,3'd0,8'h00,Z, F,F,Z, F,F,Z};
    vt[4] = '{T,IA1,T,DA,3'd3,8'hFF,WD, F,F,Z,
              F,Z,3'd0,8'h00,Z, F,F,Z, F,F,Z};
    vt[5] = '{T,IA1,T,DA,3'd3,8'hFF,WD, T,T,64'h77,
              T,DA,3'd3,8'hFF,WD, F,F,Z, T,T,64'h77};
    vt[6] = '{T,IA1,F,Z,3'd0,8'h00,Z, F,F,Z,
              F,Z,3'd0,8'h00,Z, F,F,Z, F,F,Z};
    vt[7] = '{T,IA1,F,Z,3'd0,8'h00,Z, T,T,64'h55,
              T,IA1,3'd2,8'h00,Z, T,T,64'h55, F,F,Z};
    vt[8] = '{F,Z,F,Z,3'd0,8'h00,Z, F,F,Z,
              F,Z,3'd0,8'h00,Z, F,F,Z, F,F,Z};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord = '{1, 0, 1, 1, 1};
`else
    exp_ord = '{1, 1, 1, 1, 0};
`endif

    // reset state
    rst = 1;
    idle_inputs();
    model_reset();
    model_on = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mv", mreq_valid, 0);
    chk("rst_maddr", mreq_addr, 0);
    chk("rst_msize", mreq_size, 0);
    chk("rst_mstrb", mreq_strobe, 0);
    chk("rst_mwdata", mreq_wdata, 0);
    chk("rst_iaok", iresp_addr_ok, 0);
    chk("rst_idok", iresp_data_ok, 0);
    chk("rst_daok", dresp_addr_ok, 0);
    chk("rst_ddok", dresp_data_ok, 0);
    @(negedge clk);
    rst = 0;

    // table: single ibus read, then contention with a dbus write
    for (int i = 0; i < 9; i++) begin
      ireq_valid = vt[i].iv; ireq_addr = vt[i].ia;
      dreq_valid = vt[i].dv; dreq_addr = vt[i].da;
      dreq_size = vt[i].dsz; dreq_strobe = vt[i].dst;
      dreq_wdata = vt[i].dwd;
      mresp_addr_ok = vt[i].maok; mresp_data_ok = vt[i].mdok;
      mresp_data = vt[i].mdat;
      settle();
      chk($sformatf("v%0d_mv", i), mreq_valid, vt[i].mv);
      if (vt[i].mv) begin
        chk($sformatf("v%0d_maddr", i), mreq_addr, vt[i].maddr);
        chk($sformatf("v%0d_msize", i), mreq_size, vt[i].msz);
        chk($sformatf("v%0d_mstrb", i), mreq_strobe, vt[i].mstb);
        chk($sformatf("v%0d_mwdata", i), mreq_wdata, vt[i].mwd);
      end
      chk($sformatf("v%0d_iaok", i), iresp_addr_ok, vt[i].iaok);
      chk($sformatf("v%0d_idok", i), iresp_data_ok, vt[i].idok);
      chk($sformatf("v%0d_idata", i), iresp_data, vt[i].idat);
      chk($sformatf("v%0d_daok", i), dresp_addr_ok, vt[i].daok);
      chk($sformatf("v%0d_ddok", i), dresp_data_ok, vt[i].ddok);
      chk($sformatf("v%0d_ddata", i), dresp_data, vt[i].ddat);
      advance();
    end
    model_on = 1;

    // continuous dbus stream of 4 reads with ibus waiting
    ord.delete();
    drem = 4;
    idone = 0;
    for (int c = 0; c < 40 && !(drem == 0 && idone); c++) begin
      dreq_valid = (drem > 0);
      dreq_addr = 64'h3000 + 64'(8 * (4 - drem));
      dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_wdata = '0;
      ireq_valid = !idone; ireq_addr = 64'h8000_0040;
      mresp_addr_ok = m_busy; mresp_data_ok = m_busy;
      mresp_data = {$urandom, $urandom};
      settle();
      if (e_ddok) drem--;
      if (e_idok) idone = 1;
      advance();
    end
    chk("starve_done", 64'(drem == 0 && idone), 1);
    chk("starve_len", ord.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("order%0d", k),
          (k < ord.size()) ? 64'(ord[k]) : 64'd2, exp_ord[k]);

    // memory stalls a dbus read for 5 cycles, ibus pending
    idle_inputs();
    dreq_valid = 1; dreq_addr = 64'h2008; dreq_size = 3'd3;
    settle();
    advance();
    ireq_valid = 1; ireq_addr = 64'h8000_0100;
    for (int k = 1; k <= 5; k++) begin
      mresp_addr_ok = (k == 1);
      mresp_data_ok = (k == 5);
      mresp_data = 64'hCAFE_0000 + 64'(k);
      settle();
      chk("stall_valid", mreq_valid, 1);
      chk("stall_addr", mreq_addr, 64'h2008);
      chk("stall_size", mreq_size, 3'd3);
      chk("stall_strb", mreq_strobe, 0);
      chk("stall_ddok", dresp_data_ok, 64'(k == 5));
      chk("stall_idok", iresp_data_ok, 0);
      advance();
    end
    dreq_valid = 0; mresp_addr_ok = 0; mresp_data_ok = 0;
    settle();
    chk("gap_idle", mreq_valid, 0);
    advance();
    mresp_addr_ok = 1; mresp_data_ok = 1; mresp_data = 64'h1234;
    settle();
    chk("pend_i_addr", mreq_addr, 64'h8000_0100);
    chk("pend_i_ok", iresp_data_ok, 1);
    chk("pend_i_data", iresp_data, 64'h1234);
    advance();
    idle_inputs();
    settle();
    advance();

    // reset in the middle of an ibus transaction
    ireq_valid = 1; ireq_addr = 64'h8000_0200;
    settle();
    advance();
    repeat (2) begin
      settle();
      advance();
    end
    rst = 1;
    #1;
    chk("rst_mid_mv", mreq_valid, 0);
    chk("rst_mid_idok", iresp_data_ok, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    ireq_valid = 0;
    mresp_data_ok = 1; mresp_data = 64'hBAD;
    settle();
    chk("late_mv", mreq_valid, 0);
    chk("late_idok", iresp_data_ok, 0);
    chk("late_ddok", dresp_data_ok, 0);
    advance();

    // spurious data_ok on an idle bus
    mresp_addr_ok = 1; mresp_data_ok = 1; mresp_data = 64'h5A5A;
    settle();
    chk("spur_idata", iresp_data, 0);
    chk("spur_ddata", dresp_data, 0);
    chk("spur_daok", dresp_addr_ok, 0);
    advance();
    idle_inputs();

    // random traffic against the model
    ipend = 0;
    dpend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1;
        ireq_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1;
        dreq_addr = {$urandom, $urandom};
        dreq_size = 3'($urandom_range(0, 3));
        dreq_strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        dreq_wdata = {$urandom, $urandom};
      end
      ireq_valid = ipend;
      dreq_valid = dpend;
      mresp_addr_ok = m_busy && ($urandom_range(0, 1) == 1);
      mresp_data_ok = m_busy && ($urandom_range(0, 2) == 0);
      mresp_data = {$urandom, $urandom};
      settle();
      if (e_idok) ipend = 0;
      if (e_ddok) dpend = 0;
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
